// File: rtl/conversor_pkg.sv
// conversor_pkg: shared types and constants for the binary-to-BCD converter
package conversor_pkg;
  typedef enum logic [1:0] {OCIOSO, DESLOCA, FIM} estado_t;
  localparam int NIBBLE_W = 4;
  localparam int AJUSTE_LIMIAR = 5;
  localparam int AJUSTE_SOMA = 3;
  function automatic logic digitos_suficientes(int w, int d);
    return real'(d) * 3.321928094887362 > real'(w);
  endfunction
endpackage

// File: rtl/conversor_bcd_if.sv
// conversor_bcd_if: request/result bundle; estouro exists only with CONVERSOR_OVERFLOW_EN
interface conversor_bcd_if #(parameter int WIDTH = 8, parameter int DIGITS = 3);
  logic start;
  logic [WIDTH-1:0] valor;
  logic ocupado;
  logic pronto;
  logic flag;
  logic [4*DIGITS-1:0] digitos;
`ifdef CONVERSOR_OVERFLOW_EN
  logic estouro;
  modport master(output start, valor, input ocupado, pronto, flag, digitos, estouro);
  modport slave(input start, valor, output ocupado, pronto, flag, digitos, estouro);
`else
  modport master(output start, valor, input ocupado, pronto, flag, digitos);
  modport slave(input start, valor, output ocupado, pronto, flag, digitos);
`endif
endinterface

// File: rtl/ajuste_bcd.sv
// ajuste_bcd: add-3 correction of one BCD nibble before a double-dabble shift
module ajuste_bcd
  import conversor_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nib_i,
  output logic [NIBBLE_W-1:0] nib_o
);
  assign nib_o = nib_i >= NIBBLE_W'(AJUSTE_LIMIAR) ? nib_i + NIBBLE_W'(AJUSTE_SOMA) : nib_i;
endmodule

// File: rtl/conversor_bcd.sv
// conversor_bcd: sequential shift-and-add-3 binary-to-BCD converter
// CONVERSOR_OVERFLOW_EN adds a guard nibble and the estouro saturation output.
module conversor_bcd
  import conversor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic rst,
  conversor_bcd_if.slave bus
);
`ifdef CONVERSOR_OVERFLOW_EN
  localparam int NG = DIGITS + 1;
`else
  localparam int NG = DIGITS;
  if (!digitos_suficientes(WIDTH, DIGITS)) begin : g_chk
    $error("conversor_bcd: DIGITS too small for WIDTH");
  end
`endif
  localparam int SW = NIBBLE_W * NG;
  localparam int DW = NIBBLE_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  estado_t estado_q, estado_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [SW-1:0] scr_q, scr_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  logic pronto_q, pronto_d;
  logic [SW+WIDTH-1:0] sh;
`ifdef CONVERSOR_OVERFLOW_EN
  logic est_q, est_d;
`endif
  for (genvar i = 0; i < NG; i++) begin : g_aj
    ajuste_bcd u_aj (.nib_i(scr_q[NIBBLE_W*i +: NIBBLE_W]), .nib_o(adj[NIBBLE_W*i +: NIBBLE_W]));
  end
  assign sh = {adj, bin_q} << 1;
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      dig_q <= '0;
      pronto_q <= 1'b0;
`ifdef CONVERSOR_OVERFLOW_EN
      est_q <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      bin_q <= bin_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      pronto_q <= pronto_d;
`ifdef CONVERSOR_OVERFLOW_EN
      est_q <= est_d;
`endif
    end
  end
  always_comb begin
    estado_d = estado_q == OCIOSO  ? (bus.start ? DESLOCA : OCIOSO) :
               estado_q == DESLOCA ? (cnt_q == CW'(1) ? FIM : DESLOCA) : OCIOSO;
  end
  always_comb begin
    bin_d = bin_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    dig_d = dig_q;
    pronto_d = 1'b0;
`ifdef CONVERSOR_OVERFLOW_EN
    est_d = est_q;
`endif
    if (estado_q == OCIOSO && bus.start) begin
      bin_d = bus.valor;
      scr_d = '0;
      cnt_d = CW'(WIDTH);
    end
    if (estado_q == DESLOCA) begin
      scr_d = sh[SW+WIDTH-1 -: SW];
      bin_d = sh[WIDTH-1:0];
      cnt_d = cnt_q - CW'(1);
    end
    if (estado_q == FIM) begin
      pronto_d = 1'b1;
`ifdef CONVERSOR_OVERFLOW_EN
      est_d = |scr_q[SW-1 -: NIBBLE_W];
      dig_d = est_d ? {DIGITS{4'h9}} : scr_q[DW-1:0];
`else
      dig_d = scr_q[DW-1:0];
`endif
    end
  end
  always_comb begin
    bus.ocupado = estado_q != OCIOSO;
    bus.flag = estado_q != OCIOSO;
    bus.pronto = pronto_q;
    bus.digitos = dig_q;
`ifdef CONVERSOR_OVERFLOW_EN
    bus.estouro = est_q;
`endif
  end
endmodule
